mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage initiator that turns pipeline load/store requests into accesses on the data memory port: read strobe, write strobe, 16-bit address, 16-bit write data, 16-bit registered read data.
- Memory is byte-addressed, big-endian halfword: address a returns or writes {byte[a], byte[a+1]}. Read data is valid the cycle after the read strobe is sampled.
- Supports halfword and byte loads/stores. Byte loads are sign- or zero-extended. Byte stores use read-modify-write, because the memory port writes only full halfwords.
- Stalls the pipeline while busy.

Parameters:
- ADDR_WIDTH, 16, byte address width on both sides.
- DATA_WIDTH, 16, halfword width; fixed at 16 (two byte lanes).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_Req_Valid  input  1  request present.
- i_Req_Write  input  1  1 = store, 0 = load.
- i_Req_Byte  input  1  1 = byte access, 0 = halfword.
- i_Req_Signed  input  1  byte load sign-extends when 1.
- i_Req_Address  input  ADDR_WIDTH  byte address.
- i_Req_Data  input  DATA_WIDTH  store data; byte store uses [7:0].
- o_Busy  output  1  stall; request accepted only when low.
- o_Load_Valid  output  1  one-cycle pulse, o_Load_Data valid.
- o_Load_Data  output  DATA_WIDTH  load result.
- o_Sig_MemRead  output  1  memory read strobe.
- o_Sig_MemWrite  output  1  memory write strobe.
- o_Address  output  ADDR_WIDTH  memory address.
- o_Write_Data  output  DATA_WIDTH  memory write data.
- i_Read_Data  input  DATA_WIDTH  memory read data, registered by memory.

Behaviour:
- Reset values:
  - State IDLE.
  - o_Sig_MemRead = 0, o_Sig_MemWrite = 0.
  - o_Address = 0, o_Write_Data = 0.
  - o_Load_Valid = 0, o_Load_Data = 0.
  - o_Busy = 0.
- Acceptance: on an edge with i_Req_Valid=1 and state IDLE (o_Busy=0), latch address, data, write, byte and signed into request registers. No new acceptance in any other state.
- o_Busy = (state != IDLE); decoded from the registered state.
- Memory strobes are decoded from state. o_Sig_MemRead and o_Sig_MemWrite are never both 1. In IDLE both are 0.
- FSM states: IDLE, RD, RD_WAIT, WR.
- IDLE transitions on acceptance:
  - Load -> RD.
  - Byte store -> RD.
  - Halfword store -> WR.
- RD: o_Sig_MemRead=1, o_Address=latched address. Next state RD_WAIT.
- RD_WAIT: i_Read_Data valid this cycle.
  - Load: at the edge, capture o_Load_Data and go to IDLE; o_Load_Valid=1 for exactly the following cycle.
  - Byte store: capture the low byte i_Read_Data[7:0] and go to WR.
- WR: o_Sig_MemWrite=1, o_Address=latched address. Next state IDLE.
  - Halfword store: o_Write_Data = latched i_Req_Data.
  - Byte store: o_Write_Data = {i_Req_Data[7:0], captured i_Read_Data[7:0]}, so byte[a+1] is preserved.
- Load data formatting:
  - Halfword: i_Read_Data unchanged.
  - Byte: byte = i_Read_Data[15:8]. Signed gives {8{byte[7]}, byte}; unsigned gives {8'h00, byte}.
- Latency, measured from the accept edge:
  - Halfword store: write sampled by memory 1 edge later; o_Busy high 1 cycle.
  - Load: o_Load_Valid high in the 3rd cycle after accept; o_Busy high 2 cycles.
  - Byte store: write sampled 3 edges later; o_Busy high 3 cycles.
- A new request may be accepted in the same cycle o_Load_Valid pulses.
- o_Load_Data holds its value until the next load completes.
- Address wrap: odd address 0xFFFF halfword goes out unmodified; the memory owns a+1 behaviour.
- Reset mid-operation: the next edge forces IDLE, strobes 0, o_Load_Valid 0, and the pending request is dropped.
  - rst asserted during RD or RD_WAIT of a byte store: no write is issued.
  - rst asserted in the WR cycle: memory still samples that write at the same edge; the write completes.
- i_Req_* changing while o_Busy=1: ignored.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined:
  - An extra output o_Misaligned (1 bit) is present; reset 0.
  - A halfword request with i_Req_Address[0]=1 is accepted but issues no memory access.
  - The unit stays IDLE and o_Misaligned pulses for one cycle after the accept edge.
  - o_Load_Valid stays 0 and o_Load_Data is unchanged.
- Undefined: no o_Misaligned port; odd halfword addresses are passed through as above.

Test Plan:
- After reset, memory initial image is even bytes 0x00, odd bytes 0x01. Halfword load at 0x0010 -> o_Load_Valid pulse in the 3rd cycle after accept, o_Load_Data=0x0001, o_Busy high exactly 2 cycles.
- Halfword store 0x1234 at 0x0020, then halfword load at 0x0020 -> 0x1234. The store shows one o_Sig_MemWrite cycle with o_Address=0x0020 and o_Write_Data=0x1234.
- Byte store 0xAB at 0x0040, then:
  - Signed byte load at 0x0040 -> 0xFFAB.
  - Unsigned byte load at 0x0040 -> 0x00AB.
  - Halfword load at 0x0040 -> 0xAB01 (byte 0x0041 preserved).
- Reset asserted during RD_WAIT of a byte store 0x55 at 0x0060 -> no o_Sig_MemWrite; a later halfword load at 0x0060 returns 0x0001; all outputs at reset values after the reset edge.
- i_Req_Valid held high for back-to-back requests (load 0x0010, then halfword store 0xBEEF at 0x0010, then load 0x0010):
  - Each is accepted only when o_Busy=0.
  - Read and write strobes are never high together.
  - Final o_Load_Data=0xBEEF.
- With ALIGN_CHECK_EN: halfword load at 0x0011 -> o_Misaligned one-cycle pulse, no strobes, o_Load_Valid stays 0. Without the macro: same request -> o_Load_Data=0x0100.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
//==============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store initiator on a halfword memory port; byte
//            stores are done as read-modify-write.
// Options  : ALIGN_CHECK_EN - odd-address halfword requests are accepted but
//            dropped, and o_Misaligned pulses for one cycle.
// Revision : 1.0 - initial release
//==============================================================================
module mem_access_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_Req_Valid,
    input  logic                  i_Req_Write,
    input  logic                  i_Req_Byte,
    input  logic                  i_Req_Signed,
    input  logic [ADDR_WIDTH-1:0] i_Req_Address,
    input  logic [DATA_WIDTH-1:0] i_Req_Data,
    output logic                  o_Busy,
    output logic                  o_Load_Valid,
    output logic [DATA_WIDTH-1:0] o_Load_Data,
    output logic                  o_Sig_MemRead,
    output logic                  o_Sig_MemWrite,
    output logic [ADDR_WIDTH-1:0] o_Address,
    output logic [DATA_WIDTH-1:0] o_Write_Data,
    input  logic [DATA_WIDTH-1:0] i_Read_Data
`ifdef ALIGN_CHECK_EN
    ,
    output logic                  o_Misaligned
`endif
);

    localparam int c_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR      = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_write;
    logic                  r_byte;
    logic                  r_signed;
    logic [c_BYTE_W-1:0]   r_rmw_byte;
    logic                  r_load_valid;
    logic [DATA_WIDTH-1:0] r_load_data;

    logic                  w_accept;
    logic                  w_misaligned;
    logic [c_BYTE_W-1:0]   w_load_byte;
    logic [DATA_WIDTH-1:0] w_load_fmt;

    assign w_accept = i_Req_Valid && (r_state == ST_IDLE);

`ifdef ALIGN_CHECK_EN
    assign w_misaligned = ~i_Req_Byte & i_Req_Address[0];
`else
    assign w_misaligned = 1'b0;
`endif

    // Big-endian: the addressed byte sits in the upper lane of the halfword.
    assign w_load_byte = i_Read_Data[DATA_WIDTH-1 -: c_BYTE_W];

    always_comb begin
        w_load_fmt = i_Read_Data;
        if (r_byte) begin
            if (r_signed) begin
                w_load_fmt = {{(DATA_WIDTH-c_BYTE_W){w_load_byte[c_BYTE_W-1]}}, w_load_byte};
            end else begin
                w_load_fmt = {{(DATA_WIDTH-c_BYTE_W){1'b0}}, w_load_byte};
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_misaligned) begin
                    // Byte stores read first so the neighbouring byte can be written back.
                    if (!i_Req_Write || i_Req_Byte) begin
                        w_state_next = ST_RD;
                    end else begin
                        w_state_next = ST_WR;
                    end
                end
            end
            ST_RD:      w_state_next = ST_RD_WAIT;
            ST_RD_WAIT: w_state_next = r_write ? ST_WR : ST_IDLE;
            ST_WR:      w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_rmw_byte   <= '0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_load_valid <= 1'b0;
            if (w_accept) begin
                r_addr   <= i_Req_Address;
                r_data   <= i_Req_Data;
                r_write  <= i_Req_Write;
                r_byte   <= i_Req_Byte;
                r_signed <= i_Req_Signed;
            end
            if (r_state == ST_RD_WAIT) begin
                if (r_write) begin
                    r_rmw_byte <= i_Read_Data[c_BYTE_W-1:0];
                end else begin
                    r_load_data  <= w_load_fmt;
                    r_load_valid <= 1'b1;
                end
            end
        end
    end

`ifdef ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_accept & w_misaligned;
        end
    end

    assign o_Misaligned = r_misaligned;
`endif

    // Memory-side outputs are pure decodes of the registered state.
    always_comb begin
        o_Sig_MemRead  = 1'b0;
        o_Sig_MemWrite = 1'b0;
        o_Address      = '0;
        o_Write_Data   = '0;
        case (r_state)
            ST_RD: begin
                o_Sig_MemRead = 1'b1;
                o_Address     = r_addr;
            end
            ST_WR: begin
                o_Sig_MemWrite = 1'b1;
                o_Address      = r_addr;
                o_Write_Data   = r_byte ? {r_data[c_BYTE_W-1:0], r_rmw_byte} : r_data;
            end
            default: begin
                o_Sig_MemRead  = 1'b0;
                o_Sig_MemWrite = 1'b0;
            end
        endcase
    end

    assign o_Busy       = (r_state != ST_IDLE);
    assign o_Load_Valid = r_load_valid;
    assign o_Load_Data  = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_access_unit
// Brief    : Randomized bench for mem_access_unit with a byte-array memory and
//            a transaction-level reference model (honours ALIGN_CHECK_EN).
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_Req_Valid, i_Req_Write, i_Req_Byte, i_Req_Signed;
    logic [15:0] i_Req_Address, i_Req_Data;
    logic        o_Busy, o_Load_Valid, o_Sig_MemRead, o_Sig_MemWrite;
    logic [15:0] o_Load_Data, o_Address, o_Write_Data;
    logic [15:0] r_rdata;
`ifdef ALIGN_CHECK_EN
    logic        o_Misaligned;
`endif

    logic [7:0]  r_mem   [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] exp_load_data;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_Req_Valid    (i_Req_Valid),
        .i_Req_Write    (i_Req_Write),
        .i_Req_Byte     (i_Req_Byte),
        .i_Req_Signed   (i_Req_Signed),
        .i_Req_Address  (i_Req_Address),
        .i_Req_Data     (i_Req_Data),
        .o_Busy         (o_Busy),
        .o_Load_Valid   (o_Load_Valid),
        .o_Load_Data    (o_Load_Data),
        .o_Sig_MemRead  (o_Sig_MemRead),
        .o_Sig_MemWrite (o_Sig_MemWrite),
        .o_Address      (o_Address),
        .o_Write_Data   (o_Write_Data),
        .i_Read_Data    (r_rdata)
`ifdef ALIGN_CHECK_EN
        ,
        .o_Misaligned   (o_Misaligned)
`endif
    );

    // Byte-addressed big-endian memory with registered read data.
    always @(posedge clk) begin
        if (o_Sig_MemWrite) begin
            r_mem[o_Address]         <= o_Write_Data[15:8];
            r_mem[o_Address + 16'd1] <= o_Write_Data[7:0];
        end
        if (o_Sig_MemRead) begin
            r_rdata <= {r_mem[o_Address], r_mem[o_Address + 16'd1]};
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            r_mem[i]   <= (i % 2 == 1) ? 8'h01 : 8'h00;
            ref_mem[i]  = (i % 2 == 1) ? 8'h01 : 8'h00;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (o_Sig_MemRead || o_Sig_MemWrite) begin
            check_value("strobe_excl", {31'd0, o_Sig_MemRead & o_Sig_MemWrite}, 32'd0);
        end
    end

    function automatic logic [15:0] ref_load(input bit bt, input bit sg, input logic [15:0] a);
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] a1;
        int          v;
        a1 = a + 16'd1;
        hi = ref_mem[a];
        lo = ref_mem[a1];
        if (!bt) return {hi, lo};
        v = int'(hi);
        if (sg && v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    // One isolated request, observed for four cycles after the accept edge.
    task automatic do_req(input bit wr, input bit bt, input bit sg,
                          input logic [15:0] addr, input logic [15:0] data);
        bit          mis;
        bit          is_load;
        int          exp_busy, exp_rd, exp_wr;
        int          busy_n, rd_n, wr_n, lv_n, mis_n;
        int          rd_k, wr_k, lv_k, mis_k;
        logic [15:0] exp_wd, exp_ld, a1;
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = !bt && addr[0];
`endif
        is_load = !wr && !mis;
        a1      = addr + 16'd1;
        exp_wd  = bt ? {data[7:0], ref_mem[a1]} : data;
        exp_ld  = ref_load(bt, sg, addr);
        if (mis)        begin exp_busy = 0; exp_rd = 0; exp_wr = 0; end
        else if (!wr)   begin exp_busy = 2; exp_rd = 1; exp_wr = 0; end
        else if (bt)    begin exp_busy = 3; exp_rd = 1; exp_wr = 1; end
        else            begin exp_busy = 1; exp_rd = 0; exp_wr = 1; end

        check_value("idle_pre", {31'd0, o_Busy}, 32'd0);
        i_Req_Valid = 1'b1; i_Req_Write = wr; i_Req_Byte = bt; i_Req_Signed = sg;
        i_Req_Address = addr; i_Req_Data = data;
        @(negedge clk);
        i_Req_Valid   = 1'b0;
        i_Req_Write   = 1'($urandom_range(0, 1));
        i_Req_Byte    = 1'($urandom_range(0, 1));
        i_Req_Signed  = 1'($urandom_range(0, 1));
        i_Req_Address = 16'($urandom);
        i_Req_Data    = 16'($urandom);

        busy_n = 0; rd_n = 0; wr_n = 0; lv_n = 0; mis_n = 0;
        rd_k = 0; wr_k = 0; lv_k = 0; mis_k = 0;
        for (int k = 1; k <= 4; k++) begin
            if (o_Busy) busy_n++;
            if (o_Sig_MemRead) begin
                rd_n++; rd_k = k;
                check_value("rd_addr", {16'd0, o_Address}, {16'd0, addr});
            end
            if (o_Sig_MemWrite) begin
                wr_n++; wr_k = k;
                check_value("wr_addr", {16'd0, o_Address}, {16'd0, addr});
                check_value("wr_data", {16'd0, o_Write_Data}, {16'd0, exp_wd});
            end
            if (o_Load_Valid) begin
                lv_n++; lv_k = k;
                check_value("lv_data", {16'd0, o_Load_Data}, {16'd0, exp_ld});
            end
`ifdef ALIGN_CHECK_EN
            if (o_Misaligned) begin mis_n++; mis_k = k; end
`endif
            if (k < 4) @(negedge clk);
        end

        check_value("busy_cycles", busy_n, exp_busy);
        check_value("rd_count", rd_n, exp_rd);
        check_value("wr_count", wr_n, exp_wr);
        check_value("lv_count", lv_n, is_load ? 1 : 0);
        if (exp_rd != 0) check_value("rd_cycle", rd_k, 1);
        if (exp_wr != 0) check_value("wr_cycle", wr_k, bt ? 3 : 1);
        if (is_load) begin
            check_value("lv_cycle", lv_k, 3);
            exp_load_data = exp_ld;
        end else if (!mis) begin
            if (bt) begin
                ref_mem[addr] = data[7:0];
            end else begin
                ref_mem[addr] = data[15:8];
                ref_mem[a1]   = data[7:0];
            end
        end
`ifdef ALIGN_CHECK_EN
        check_value("mis_count", mis_n, mis ? 1 : 0);
        if (mis) check_value("mis_cycle", mis_k, 1);
`endif
        check_value("load_hold", {16'd0, o_Load_Data}, {16'd0, exp_load_data});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_busy"}, {31'd0, o_Busy}, 32'd0);
        check_value({tag, "_strobes"}, {30'd0, o_Sig_MemRead, o_Sig_MemWrite}, 32'd0);
        check_value({tag, "_addr"}, {16'd0, o_Address}, 32'd0);
        check_value({tag, "_wdata"}, {16'd0, o_Write_Data}, 32'd0);
        check_value({tag, "_lv"}, {31'd0, o_Load_Valid}, 32'd0);
        check_value({tag, "_ldata"}, {16'd0, o_Load_Data}, 32'd0);
`ifdef ALIGN_CHECK_EN
        check_value({tag, "_mis"}, {31'd0, o_Misaligned}, 32'd0);
`endif
    endtask

    // Back-to-back requests with i_Req_Valid held high; acceptance is scheduled by the model.
    task automatic run_back_to_back();
        bit          b_wr [3]   = '{1'b0, 1'b1, 1'b0};
        logic [15:0] b_data [3] = '{16'h0000, 16'hBEEF, 16'h0000};
        int          acc [3];
        int          dur [3];
        logic [15:0] exp_ld [3];
        int          last;
        int          cur;
        bit          exp_busy, exp_lv;
        logic [15:0] exp_lv_data;
        for (int i = 0; i < 3; i++) begin
            dur[i] = b_wr[i] ? 1 : 2;
            acc[i] = (i == 0) ? 0 : acc[i-1] + dur[i-1] + 1;
            if (!b_wr[i]) begin
                exp_ld[i] = ref_load(1'b0, 1'b0, 16'h0010);
            end else begin
                exp_ld[i] = 16'h0000;
                ref_mem[16'h0010] = b_data[i][15:8];
                ref_mem[16'h0011] = b_data[i][7:0];
            end
        end
        last = acc[2] + 4;
        for (int c = 0; c <= last; c++) begin
            exp_busy = 1'b0; exp_lv = 1'b0; exp_lv_data = 16'h0000; cur = -1;
            for (int i = 0; i < 3; i++) begin
                if (c > acc[i] && c <= acc[i] + dur[i]) exp_busy = 1'b1;
                if (!b_wr[i] && c == acc[i] + 3) begin exp_lv = 1'b1; exp_lv_data = exp_ld[i]; end
                if (cur < 0 && c <= acc[i]) cur = i;
            end
            check_value("b2b_busy", {31'd0, o_Busy}, {31'd0, exp_busy});
            check_value("b2b_lv", {31'd0, o_Load_Valid}, {31'd0, exp_lv});
            if (exp_lv) check_value("b2b_ldata", {16'd0, o_Load_Data}, {16'd0, exp_lv_data});
            if (cur >= 0) begin
                i_Req_Valid = 1'b1; i_Req_Write = b_wr[cur]; i_Req_Byte = 1'b0;
                i_Req_Signed = 1'b0; i_Req_Address = 16'h0010; i_Req_Data = b_data[cur];
            end else begin
                i_Req_Valid = 1'b0;
            end
            @(negedge clk);
        end
        exp_load_data = exp_ld[2];
        check_value("b2b_final", {16'd0, o_Load_Data}, 32'h0000BEEF);
    endtask

    initial begin
        rst = 1'b1; i_Req_Valid = 1'b0; i_Req_Write = 1'b0; i_Req_Byte = 1'b0;
        i_Req_Signed = 1'b0; i_Req_Address = 16'h0000; i_Req_Data = 16'h0000;
        exp_load_data = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        check_value("tp_first_load", {16'd0, o_Load_Data}, 32'h00000001);
        do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234);
        do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000);
        check_value("tp_hw_rt", {16'd0, o_Load_Data}, 32'h00001234);
        do_req(1'b1, 1'b1, 1'b0, 16'h0040, 16'h77AB);
        do_req(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000);
        check_value("tp_sb", {16'd0, o_Load_Data}, 32'h0000FFAB);
        do_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
        check_value("tp_ub", {16'd0, o_Load_Data}, 32'h000000AB);
        do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
        check_value("tp_rmw", {16'd0, o_Load_Data}, 32'h0000AB01);
        do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000);

        // Reset lands on the RD_WAIT cycle of a byte store.
        i_Req_Valid = 1'b1; i_Req_Write = 1'b1; i_Req_Byte = 1'b1; i_Req_Signed = 1'b0;
        i_Req_Address = 16'h0060; i_Req_Data = 16'h0055;
        @(negedge clk);
        i_Req_Valid = 1'b0;
        check_value("rst_mid_rd", {31'd0, o_Sig_MemRead}, 32'd1);
        @(negedge clk);
        check_value("rst_mid_busy", {31'd0, o_Busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_load_data = 16'h0000;
        check_reset_outputs("rst_mid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_value("rst_mid_nowr", {31'd0, o_Sig_MemWrite}, 32'd0);
        end
        do_req(1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000);
        check_value("tp_rst_load", {16'd0, o_Load_Data}, 32'h00000001);

        run_back_to_back();

        for (int n = 0; n < 150; n++) begin
            bit          wr, bt, sg;
            logic [15:0] addr, data;
            wr   = 1'($urandom_range(0, 1));
            bt   = 1'($urandom_range(0, 1));
            sg   = 1'($urandom_range(0, 1));
            data = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       addr = 16'($urandom);
                1:       addr = 16'hFFFF - 16'($urandom_range(0, 1));
                default: addr = 16'($urandom_range(16'h0080, 16'h009F));
            endcase
            do_req(wr, bt, sg, addr, data);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
